// File: rtl/axil_pkg.sv
// axil_pkg: AXI4-Lite response codes, register map and command-master state encoding.
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [3:0] REG_OUTPUT_MODE = 4'h0;
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
endpackage

// File: rtl/axil_cfg_master.sv
// axil_cfg_master: turns single register commands into one-at-a-time AXI4-Lite transactions.
module axil_cfg_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  write_q, aw_done, w_done, aw_hs, w_hs, busy;
    logic [CW-1:0]         wd_cnt;
    assign cmd_ready     = state == IDLE;
    assign m_axi_awvalid = state == WR && !aw_done;
    assign m_axi_wvalid  = state == WR && !w_done;
    assign m_axi_bready  = state == WR_RESP;
    assign m_axi_arvalid = state == RD_ADDR;
    assign m_axi_rready  = state == RD_DATA;
    assign rsp_valid     = state == RSP;
    assign rsp_write     = write_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign busy          = state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
    always_ff @(posedge aclk) state <= areset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid) state_n = cmd_write ? WR : RD_ADDR;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_n = RSP;
            RD_ADDR: if (m_axi_arready) state_n = RD_DATA;
            RD_DATA: if (m_axi_rvalid) state_n = RSP;
            RSP:     if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wd_cnt      <= '0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                wd_cnt  <= '0;
            end else if (busy && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (m_axi_bvalid && m_axi_bready) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_bresp;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
            // flag on the edge where the counter reaches TIMEOUT_CYCLES
            if (TIMEOUT_CYCLES != 0 && busy && wd_cnt == TO_LAST) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axil_cfg_master.sv
// tb_axil_cfg_master: randomized register traffic against a behavioural AXI4-Lite slave and register model.
module tb_axil_cfg_master;
    import axil_pkg::*;
    logic aclk = 1'b0, areset = 1'b1;
    logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [3:0] cmd_addr = '0, cmd_wstrb = '0;
    logic [31:0] cmd_wdata = '0;
    logic cmd_ready, rsp_valid, rsp_write, timeout_err;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [3:0] m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [1:0] m_axi_bresp, m_axi_rresp;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
    logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    int checks = 0, errors = 0;
    logic [31:0] model_mem [4];
    always #5 aclk = ~aclk;

    axil_cfg_master #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // behavioural slave with programmable wait states, sharing the master's reset
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit ar_never = 0, r_err = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    logic have_aw, have_w, r_pend;
    logic [3:0] waddr, raddr, wstb;
    logic [31:0] wdat;
    logic [31:0] smem [4];
    logic [3:0] s_a, s_s;
    logic [31:0] s_d;
    assign m_axi_awready = m_axi_awvalid && !have_aw && aw_cnt >= aw_wait;
    assign m_axi_wready  = m_axi_wvalid && !have_w && w_cnt >= w_wait;
    assign m_axi_arready = m_axi_arvalid && !ar_never && !r_pend && !m_axi_rvalid && ar_cnt >= ar_wait;
    assign s_a = have_aw ? waddr : m_axi_awaddr;
    assign s_d = have_w ? wdat : m_axi_wdata;
    assign s_s = have_w ? wstb : m_axi_wstrb;
    always @(posedge aclk) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            have_aw <= 0; have_w <= 0; r_pend <= 0;
            m_axi_bvalid <= 0; m_axi_rvalid <= 0; m_axi_bresp <= 0; m_axi_rresp <= 0; m_axi_rdata <= 0;
            waddr <= 0; raddr <= 0; wdat <= 0; wstb <= 0;
            for (int k = 0; k < 4; k++) smem[k] <= 0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
            if (m_axi_awvalid && m_axi_awready) begin
                have_aw <= 1; waddr <= m_axi_awaddr; aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1;
            end
            if (m_axi_wvalid && !m_axi_wready) w_cnt <= w_cnt + 1;
            if (m_axi_wvalid && m_axi_wready) begin
                have_w <= 1; wdat <= m_axi_wdata; wstb <= m_axi_wstrb; w_cnt <= 0; w_hs_n <= w_hs_n + 1;
            end
            if (!m_axi_bvalid && (have_aw || (m_axi_awvalid && m_axi_awready)) &&
                (have_w || (m_axi_wvalid && m_axi_wready))) begin
                if (b_cnt >= b_wait) begin
                    m_axi_bvalid <= 1; m_axi_bresp <= RESP_OKAY; b_cnt <= 0;
                    for (int k = 0; k < 4; k++) if (s_s[k]) smem[s_a[3:2]][8*k +: 8] <= s_d[8*k +: 8];
                end else b_cnt <= b_cnt + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 0; have_aw <= 0; have_w <= 0; b_hs_n <= b_hs_n + 1;
            end
            if (m_axi_arvalid && !m_axi_arready) ar_cnt <= ar_cnt + 1;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt <= 0;
                if (r_wait == 0) begin
                    m_axi_rvalid <= 1;
                    m_axi_rdata <= r_err ? 32'hDEADBEEF : smem[m_axi_araddr[3:2]];
                    m_axi_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    r_pend <= 1; raddr <= m_axi_araddr; r_cnt <= 1;
                end
            end
            if (r_pend) begin
                if (r_cnt >= r_wait) begin
                    r_pend <= 0; m_axi_rvalid <= 1;
                    m_axi_rdata <= r_err ? 32'hDEADBEEF : smem[raddr[3:2]];
                    m_axi_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                end else r_cnt <= r_cnt + 1;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
        end
    end

    // AXI valid/stability rules and response-port stability, sampled mid-cycle
    bit mon_en = 0;
    int mon_errs = 0;
    logic p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_rw;
    logic [3:0] p_awa, p_ara, p_ws;
    logic [31:0] p_wd, p_rd;
    logic [1:0] p_rs;
    always @(negedge aclk) begin
        if (mon_en && !p_rst) begin
            if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awa)) begin
                mon_errs <= mon_errs + 1; $display("FAIL aw_hold: awvalid=%b awaddr=%h required 1/%h", m_axi_awvalid, m_axi_awaddr, p_awa);
            end
            if (p_awv && p_awr && m_axi_awvalid) begin
                mon_errs <= mon_errs + 1; $display("FAIL aw_drop: awvalid=%b required 0", m_axi_awvalid);
            end
            if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata !== p_wd || m_axi_wstrb !== p_ws)) begin
                mon_errs <= mon_errs + 1; $display("FAIL w_hold: wvalid=%b wdata=%h required 1/%h", m_axi_wvalid, m_axi_wdata, p_wd);
            end
            if (p_wv && p_wr && m_axi_wvalid) begin
                mon_errs <= mon_errs + 1; $display("FAIL w_drop: wvalid=%b required 0", m_axi_wvalid);
            end
            if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_ara)) begin
                mon_errs <= mon_errs + 1; $display("FAIL ar_hold: arvalid=%b araddr=%h required 1/%h", m_axi_arvalid, m_axi_araddr, p_ara);
            end
            if (p_rv && !p_rr && (!rsp_valid || rsp_write !== p_rw || rsp_rdata !== p_rd || rsp_resp !== p_rs)) begin
                mon_errs <= mon_errs + 1;
                $display("FAIL rsp_hold: valid=%b write=%b rdata=%h resp=%0d required 1/%b/%h/%0d", rsp_valid, rsp_write, rsp_rdata, rsp_resp, p_rw, p_rd, p_rs);
            end
        end
        p_rst <= areset; p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awa <= m_axi_awaddr;
        p_wv <= m_axi_wvalid; p_wr <= m_axi_wready; p_wd <= m_axi_wdata; p_ws <= m_axi_wstrb;
        p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_ara <= m_axi_araddr;
        p_rv <= rsp_valid; p_rr <= rsp_ready; p_rw <= rsp_write; p_rd <= rsp_rdata; p_rs <= rsp_resp;
    end

    task automatic model_clear();
        for (int k = 0; k < 4; k++) model_mem[k] = 32'h0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++) if (s[k]) model_mem[a[3:2]][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        model_clear();
    endtask

    // issue one command, hold off the response for `stall` cycles, return what came back
    task automatic run_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int stall, output bit ok, output bit o_w, output logic [31:0] o_d,
                           output logic [1:0] o_r, output int lat);
        int n = 0;
        ok = 0; o_w = 0; o_d = 0; o_r = 0; lat = 0;
        while (!cmd_ready && n < 100) begin @(posedge aclk); #1; n++; end
        if (!cmd_ready) begin
            checks++; errors++; $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge aclk); #1;
        cmd_valid = 0; lat = 1;
        while (!rsp_valid && lat < 200) begin
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready: cmd_ready=%b required 0", cmd_ready); end
            @(posedge aclk); #1; lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++; $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge aclk); #1;
            checks++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
                errors++; $display("FAIL rsp_stall: cmd_ready=%b rsp_valid=%b required 0/1", cmd_ready, rsp_valid);
            end
        end
        o_w = rsp_write; o_d = rsp_rdata; o_r = rsp_resp;
        rsp_ready = 1;
        @(posedge aclk); #1;
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_done: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
        end
        ok = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 7'b1000000) begin
            errors++; $display("FAIL reset_handshake: rdy/vld=%b required 1000000",
                {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        checks++;
        if (rsp_rdata !== 0 || rsp_resp !== 0 || rsp_write !== 0 || timeout_err !== 0 || m_axi_awaddr !== 0 || m_axi_wdata !== 0) begin
            errors++; $display("FAIL reset_data: rdata=%h resp=%0d write=%b to=%b awaddr=%h wdata=%h required all 0",
                rsp_rdata, rsp_resp, rsp_write, timeout_err, m_axi_awaddr, m_axi_wdata);
        end
        areset = 0;
        model_clear();
        mon_en = 1;
    endtask

    task automatic test_basic();
        bit ok, w; logic [31:0] d; logic [1:0] r; int lat;
        run_cmd(1, REG_OUTPUT_MODE, 32'h2, 4'hF, 0, ok, w, d, r, lat);
        model_write(REG_OUTPUT_MODE, 32'h2, 4'hF);
        checks++;
        if (!ok || w !== 1 || d !== 0 || r !== RESP_OKAY || lat != 3) begin
            errors++; $display("FAIL basic_write: write=%b rdata=%h resp=%0d lat=%0d required 1/0/0/3", w, d, r, lat);
        end
        run_cmd(0, REG_OUTPUT_MODE, 32'h0, 4'h0, 0, ok, w, d, r, lat);
        checks++;
        if (!ok || w !== 0 || d !== 32'h2 || r !== RESP_OKAY || lat != 3) begin
            errors++; $display("FAIL basic_read: write=%b rdata=%h resp=%0d lat=%0d required 0/00000002/0/3", w, d, r, lat);
        end
    endtask

    task automatic test_random();
        bit ok, w, wr; logic [31:0] d, wd; logic [1:0] r; logic [3:0] a, s; int lat;
        for (int i = 0; i < 24; i++) begin
            aw_wait = $urandom_range(0, 1); w_wait = $urandom_range(0, 1); b_wait = $urandom_range(0, 1);
            ar_wait = $urandom_range(0, 1); r_wait = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1)); a = {2'($urandom_range(0, 3)), 2'b00};
            wd = $urandom; s = 4'($urandom_range(0, 15));
            run_cmd(wr, a, wd, s, $urandom_range(0, 2), ok, w, d, r, lat);
            if (wr) model_write(a, wd, s);
            checks++;
            if (!ok || w !== wr || d !== (wr ? 32'h0 : model_mem[a[3:2]]) || r !== RESP_OKAY) begin
                errors++; $display("FAIL random_%0d: write=%b rdata=%h resp=%0d required %b/%h/0",
                    i, w, d, r, wr, wr ? 32'h0 : model_mem[a[3:2]]);
            end
        end
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL random_timeout: timeout_err=%b required 0", timeout_err); end
    endtask

    task automatic test_w_before_aw();
        bit ok, w; logic [31:0] d, wd; logic [1:0] r; int lat, aw0, w0, b0;
        aw_wait = 2; wd = $urandom;
        aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        run_cmd(1, 4'h4, wd, 4'hF, 0, ok, w, d, r, lat);
        model_write(4'h4, wd, 4'hF);
        aw_wait = 0;
        checks++;
        if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1 || b_hs_n - b0 != 1) begin
            errors++; $display("FAIL w_first_hs: aw=%0d w=%0d b=%0d required 1/1/1", aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0);
        end
        run_cmd(0, 4'h4, 0, 0, 0, ok, w, d, r, lat);
        checks++;
        if (!ok || d !== model_mem[1] || r !== RESP_OKAY) begin
            errors++; $display("FAIL w_first_read: rdata=%h resp=%0d required %h/0", d, r, model_mem[1]);
        end
    endtask

    task automatic test_stalls();
        bit ok, w; logic [31:0] d, wd; logic [1:0] r; int lat, b0;
        b_wait = 5; wd = $urandom; b0 = b_hs_n;
        run_cmd(1, 4'h8, wd, 4'h5, 3, ok, w, d, r, lat);
        model_write(4'h8, wd, 4'h5);
        b_wait = 0;
        checks++;
        if (!ok || w !== 1 || d !== 0 || r !== RESP_OKAY || b_hs_n - b0 != 1) begin
            errors++; $display("FAIL stall_write: write=%b rdata=%h resp=%0d bhs=%0d required 1/0/0/1", w, d, r, b_hs_n - b0);
        end
    endtask

    task automatic test_slverr();
        bit ok, w; logic [31:0] d; logic [1:0] r; int lat;
        r_err = 1;
        run_cmd(0, 4'h8, 0, 0, 1, ok, w, d, r, lat);
        r_err = 0;
        checks++;
        if (!ok || w !== 0 || d !== 32'hDEADBEEF || r !== RESP_SLVERR) begin
            errors++; $display("FAIL slverr_read: write=%b rdata=%h resp=%0d required 0/deadbeef/2", w, d, r);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        pulse_reset();
        ar_never = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0;
        @(posedge aclk); #1;
        cmd_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge aclk); #1;
            if (i == 7) begin
                checks++;
                if (timeout_err !== 1'b0 || m_axi_arvalid !== 1'b1) begin
                    errors++; $display("FAIL timeout_early: timeout_err=%b arvalid=%b required 0/1", timeout_err, m_axi_arvalid);
                end
            end
        end
        checks++;
        if (timeout_err !== 1'b1 || m_axi_arvalid !== 1'b1) begin
            errors++; $display("FAIL timeout_rise: timeout_err=%b arvalid=%b required 1/1", timeout_err, m_axi_arvalid);
        end
        repeat (4) @(posedge aclk);
        #1;
        ar_never = 0;
        while (!rsp_valid && n < 50) begin @(posedge aclk); #1; n++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_complete: rsp_valid=%b rdata=%h timeout_err=%b required 1/0/1", rsp_valid, rsp_rdata, timeout_err);
        end
        rsp_ready = 1;
        @(posedge aclk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_wr_resp();
        bit ok, w; logic [31:0] d, wd; logic [1:0] r; int lat, n = 0;
        pulse_reset();
        b_wait = 20;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
        @(posedge aclk); #1;
        cmd_valid = 0;
        while (!(m_axi_bready && timeout_err) && n < 60) begin @(posedge aclk); #1; n++; end
        checks++;
        if (m_axi_bready !== 1'b1 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL mid_wr_resp: bready=%b timeout_err=%b required 1/1", m_axi_bready, timeout_err);
        end
        pulse_reset();
        b_wait = 0;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready, timeout_err} !== 8'b00000010) begin
            errors++; $display("FAIL abort_reset: aw/w/ar/b/r/rsp/cmd/to=%b required 00000010",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, cmd_ready, timeout_err});
        end
        wd = $urandom;
        run_cmd(1, 4'hC, wd, 4'hF, 0, ok, w, d, r, lat);
        model_write(4'hC, wd, 4'hF);
        checks++;
        if (!ok || w !== 1 || r !== RESP_OKAY || lat != 3) begin
            errors++; $display("FAIL post_reset_write: write=%b resp=%0d lat=%0d required 1/0/3", w, r, lat);
        end
        run_cmd(0, 4'hC, 0, 0, 0, ok, w, d, r, lat);
        checks++;
        if (!ok || d !== model_mem[3] || r !== RESP_OKAY) begin
            errors++; $display("FAIL post_reset_read: rdata=%h resp=%0d required %h/0", d, r, model_mem[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_w_before_aw();
        test_stalls();
        test_slverr();
        test_timeout();
        test_reset_mid_wr_resp();
        @(posedge aclk); #1;
        checks++;
        if (mon_errs != 0) begin errors++; $display("FAIL protocol_monitor: violations=%0d required 0", mon_errs); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
